// File: rtl/mac_frame_builder_if.sv
// rtl/mac_frame_builder_if.sv - request, payload and MAC TX stream signals of the frame builder
interface mac_frame_builder_if;
  logic        tx_req_in;
  logic        tx_ack_out;
  logic [47:0] tx_dst_mac_in;
  logic [15:0] tx_ethertype_in;
  logic [7:0]  pay_tdata_in;
  logic        pay_tvalid_in;
  logic        pay_tready_out;
  logic        pay_tlast_in;
  logic [7:0]  mac_tdata_out;
  logic        mac_tvalid_out;
  logic        mac_tready_in;
  logic        mac_tlast_out;
  logic        tx_busy_out;
  logic        tx_done_out;
  logic        tx_trunc_out;

  // Requester / payload source / MAC sink side
  modport master (
    output tx_req_in, tx_dst_mac_in, tx_ethertype_in,
    output pay_tdata_in, pay_tvalid_in, pay_tlast_in,
    output mac_tready_in,
    input  tx_ack_out, pay_tready_out,
    input  mac_tdata_out, mac_tvalid_out, mac_tlast_out,
    input  tx_busy_out, tx_done_out, tx_trunc_out
  );

  // Frame builder side
  modport slave (
    input  tx_req_in, tx_dst_mac_in, tx_ethertype_in,
    input  pay_tdata_in, pay_tvalid_in, pay_tlast_in,
    input  mac_tready_in,
    output tx_ack_out, pay_tready_out,
    output mac_tdata_out, mac_tvalid_out, mac_tlast_out,
    output tx_busy_out, tx_done_out, tx_trunc_out
  );
endinterface

// File: rtl/mac_frame_builder.sv
// rtl/mac_frame_builder.sv - Ethernet II frame builder: header, payload pass-through, zero pad, truncation
module mac_frame_builder #(
  parameter logic [47:0] LOCAL_MAC   = 48'hABCD_1234_5678,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500
) (
  input  logic               logic_clk,
  input  logic               logic_rst,
  mac_frame_builder_if.slave bus
);

  localparam logic [11:0] MIN_P = 12'(MIN_PAYLOAD);
  localparam logic [11:0] MAX_P = 12'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PAD,
    S_DROP
  } state_t;

  state_t      state;
  logic [3:0]  hdr_cnt;
  logic [10:0] pay_cnt;
  logic [47:0] dst_q;
  logic [15:0] type_q;
  logic        ack_q;
  logic        done_q;
  logic        trunc_q;

  logic [111:0] hdr_vec;
  logic [111:0] hdr_shift;
  logic [7:0]   hdr_byte;
  logic [11:0]  pay_inc;
  logic         pay_hs;
  logic         mac_hs;

  // Header byte selection: shift the 14-byte header so the current byte sits on top
  assign hdr_vec   = {dst_q, LOCAL_MAC, type_q};
  assign hdr_shift = hdr_vec << {hdr_cnt, 3'b000};
  assign hdr_byte  = hdr_shift[111:104];
  assign pay_inc   = {1'b0, pay_cnt} + 12'd1;

  // Output steering per state; header and pad come from registers, payload passes straight through
  always_comb begin
    bus.mac_tdata_out  = 8'h00;
    bus.mac_tvalid_out = 1'b0;
    bus.mac_tlast_out  = 1'b0;
    bus.pay_tready_out = 1'b0;
    case (state)
      S_HEADER: begin
        bus.mac_tdata_out  = hdr_byte;
        bus.mac_tvalid_out = 1'b1;
      end
      S_PAYLOAD: begin
        bus.mac_tdata_out  = bus.pay_tdata_in;
        bus.mac_tvalid_out = bus.pay_tvalid_in;
        bus.pay_tready_out = bus.mac_tready_in;
        bus.mac_tlast_out  = (bus.pay_tlast_in && (pay_inc >= MIN_P)) || (pay_inc == MAX_P);
      end
      S_PAD: begin
        bus.mac_tvalid_out = 1'b1;
        bus.mac_tlast_out  = (pay_inc == MIN_P);
      end
      S_DROP: begin
        bus.pay_tready_out = 1'b1;
      end
      default: ;
    endcase
  end

  assign pay_hs = bus.pay_tvalid_in && bus.pay_tready_out;
  assign mac_hs = bus.mac_tvalid_out && bus.mac_tready_in;

  assign bus.tx_ack_out   = ack_q;
  assign bus.tx_busy_out  = (state != S_IDLE);
  assign bus.tx_done_out  = done_q;
  assign bus.tx_trunc_out = trunc_q;

  // Frame sequencing FSM with registered ack and status pulses
  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state   <= S_IDLE;
      hdr_cnt <= 4'd0;
      pay_cnt <= 11'd0;
      dst_q   <= 48'd0;
      type_q  <= 16'd0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      trunc_q <= 1'b0;
      case (state)
        S_IDLE: begin
          ack_q <= 1'b1;
          if (bus.tx_req_in && ack_q) begin
            dst_q   <= bus.tx_dst_mac_in;
            type_q  <= bus.tx_ethertype_in;
            hdr_cnt <= 4'd0;
            pay_cnt <= 11'd0;
            ack_q   <= 1'b0;
            state   <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (mac_hs) begin
            hdr_cnt <= hdr_cnt + 4'd1;
            if (hdr_cnt == 4'd13) begin
              state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (pay_hs) begin
            pay_cnt <= pay_inc[10:0];
            if (bus.pay_tlast_in) begin
              if (pay_inc >= MIN_P) begin
                done_q <= 1'b1;
                ack_q  <= 1'b1;
                state  <= S_IDLE;
              end else begin
                state <= S_PAD;
              end
            end else if (pay_inc == MAX_P) begin
              done_q  <= 1'b1;
              trunc_q <= 1'b1;
              state   <= S_DROP;
            end
          end
        end
        S_PAD: begin
          if (mac_hs) begin
            pay_cnt <= pay_inc[10:0];
            if (pay_inc == MIN_P) begin
              done_q <= 1'b1;
              ack_q  <= 1'b1;
              state  <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (pay_hs && bus.pay_tlast_in) begin
            ack_q <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_frame_builder.sv
// tb/tb_mac_frame_builder.sv - directed bench for mac_frame_builder
module tb_mac_frame_builder;

  logic clk;
  logic rst;
  mac_frame_builder_if bus ();

  mac_frame_builder dut (
    .logic_clk (clk),
    .logic_rst (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  logic [7:0] out_q[$];
  logic       last_q[$];
  logic [7:0] exp_q[$];
  int  done_cnt, trunc_cnt, stable_err, hdr_gap, pay_used;
  bit  timed_out, aborted;
  logic abort_vld, abort_done, abort_ack, end_ack;

  // Expected frame: header, payload bytes (index mod 256), capped at 1500, zero pad to 46
  function automatic void build_exp(input logic [47:0] dst, input logic [15:0] et, input int len);
    logic [47:0] lm;
    int n;
    lm = 48'hABCD_1234_5678;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(lm[47-8*i -: 8]);
    exp_q.push_back(et[15:8]);
    exp_q.push_back(et[7:0]);
    n = (len > 1500) ? 1500 : len;
    for (int i = 0; i < n; i++) exp_q.push_back(8'(i));
    for (int i = n; i < 46; i++) exp_q.push_back(8'h00);
  endfunction

  function automatic int first_diff();
    int n;
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (out_q[i] !== exp_q[i]) return i;
    if (out_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int last_count();
    int c;
    c = 0;
    foreach (last_q[i]) if (last_q[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int last_pos();
    int p;
    p = -1;
    foreach (last_q[i]) if (last_q[i] === 1'b1) p = i;
    return p;
  endfunction

  // Issue one request and run the payload/MAC streams; abort_at >= 0 asserts reset when that output byte is presented
  task automatic run_frame(input logic [47:0] dst, input logic [15:0] et, input int len,
                           input bit stall, input int abort_at);
    int cyc;
    bit held, pend;
    logic [7:0] held_d;
    logic held_l;
    out_q.delete(); last_q.delete();
    done_cnt = 0; trunc_cnt = 0; stable_err = 0; hdr_gap = 0; pay_used = 0;
    timed_out = 0; aborted = 0; held = 0; pend = 0; held_d = 8'h00; held_l = 1'b0;
    @(negedge clk);
    bus.tx_req_in = 1'b1; bus.tx_dst_mac_in = dst; bus.tx_ethertype_in = et;
    cyc = 0;
    while (bus.tx_ack_out !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    if (cyc >= 20) begin timed_out = 1; bus.tx_req_in = 1'b0; return; end
    @(negedge clk);
    bus.tx_req_in = 1'b0;
    cyc = 0;
    while (cyc < 4000) begin
      bus.mac_tready_in = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (pay_used < len) begin
        bus.pay_tvalid_in = pend ? 1'b1 : (stall ? ($urandom_range(0, 3) != 0) : 1'b1);
        bus.pay_tdata_in  = 8'(pay_used);
        bus.pay_tlast_in  = (pay_used == len - 1);
      end else begin
        bus.pay_tvalid_in = 1'b0; bus.pay_tdata_in = 8'h00; bus.pay_tlast_in = 1'b0;
      end
      #1;
      if (held && (bus.mac_tvalid_out !== 1'b1 || bus.mac_tdata_out !== held_d ||
                   bus.mac_tlast_out !== held_l)) stable_err++;
      if (out_q.size() < 14 && bus.mac_tvalid_out !== 1'b1) hdr_gap++;
      if (bus.tx_done_out === 1'b1) done_cnt++;
      if (bus.tx_trunc_out === 1'b1) trunc_cnt++;
      if (abort_at >= 0 && out_q.size() == abort_at) begin
        rst = 1'b1;
        aborted = 1;
        @(negedge clk); #1;
        abort_vld = bus.mac_tvalid_out;
        abort_done = bus.tx_done_out;
        rst = 1'b0;
        bus.pay_tvalid_in = 1'b0; bus.pay_tlast_in = 1'b0; bus.mac_tready_in = 1'b1;
        @(negedge clk); #1;
        abort_ack = bus.tx_ack_out;
        return;
      end
      if (pay_used >= len && bus.tx_busy_out === 1'b0) begin
        end_ack = bus.tx_ack_out;
        break;
      end
      if (bus.mac_tvalid_out === 1'b1 && bus.mac_tready_in === 1'b1) begin
        out_q.push_back(bus.mac_tdata_out);
        last_q.push_back(bus.mac_tlast_out);
      end
      held = (bus.mac_tvalid_out === 1'b1) && (bus.mac_tready_in !== 1'b1);
      held_d = bus.mac_tdata_out; held_l = bus.mac_tlast_out;
      pend = (bus.pay_tvalid_in === 1'b1) && (bus.pay_tready_out !== 1'b1);
      if (bus.pay_tvalid_in === 1'b1 && bus.pay_tready_out === 1'b1) pay_used++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 4000) timed_out = 1;
    bus.pay_tvalid_in = 1'b0; bus.pay_tlast_in = 1'b0; bus.mac_tready_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.tx_ack_out !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b want=0", bus.tx_ack_out); end
    n_cmp++;
    if ({bus.mac_tvalid_out, bus.mac_tlast_out, bus.pay_tready_out, bus.tx_busy_out, bus.tx_done_out, bus.tx_trunc_out} !== 6'b0) begin
      n_bad++; $display("FAIL reset_outputs got=%b want=000000",
        {bus.mac_tvalid_out, bus.mac_tlast_out, bus.pay_tready_out, bus.tx_busy_out, bus.tx_done_out, bus.tx_trunc_out});
    end
    rst = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.tx_ack_out !== 1'b1) begin n_bad++; $display("FAIL idle_ack got=%b want=1", bus.tx_ack_out); end
  endtask

  task automatic test_long_payload();
    run_frame(48'h0102_0304_0506, 16'h0800, 100, 0, -1);
    build_exp(48'h0102_0304_0506, 16'h0800, 100);
    n_cmp++;
    if (out_q.size() != 114 || timed_out) begin n_bad++; $display("FAIL long_len got=%0d want=114 timeout=%0d", out_q.size(), timed_out); end
    n_cmp++;
    if (first_diff() != -1) begin n_bad++; $display("FAIL long_bytes first diff at %0d", first_diff()); end
    n_cmp++;
    if (last_count() != 1 || last_pos() != 113) begin n_bad++; $display("FAIL long_tlast count=%0d pos=%0d want 1 at 113", last_count(), last_pos()); end
    n_cmp++;
    if (done_cnt != 1 || trunc_cnt != 0) begin n_bad++; $display("FAIL long_pulses done=%0d trunc=%0d want 1/0", done_cnt, trunc_cnt); end
  endtask

  task automatic test_short_pad();
    run_frame(48'h0A0B_0C0D_0E0F, 16'h0806, 10, 0, -1);
    build_exp(48'h0A0B_0C0D_0E0F, 16'h0806, 10);
    n_cmp++;
    if (out_q.size() != 60 || first_diff() != -1) begin n_bad++; $display("FAIL pad_frame len=%0d want=60 diff=%0d", out_q.size(), first_diff()); end
    n_cmp++;
    if (last_count() != 1 || last_pos() != 59) begin n_bad++; $display("FAIL pad_tlast count=%0d pos=%0d want 1 at 59", last_count(), last_pos()); end
    n_cmp++;
    if (done_cnt != 1 || trunc_cnt != 0) begin n_bad++; $display("FAIL pad_pulses done=%0d trunc=%0d want 1/0", done_cnt, trunc_cnt); end
  endtask

  task automatic test_exact_min();
    run_frame(48'hFFFF_FFFF_FFFF, 16'h86DD, 46, 0, -1);
    build_exp(48'hFFFF_FFFF_FFFF, 16'h86DD, 46);
    n_cmp++;
    if (out_q.size() != 60 || first_diff() != -1) begin n_bad++; $display("FAIL min_frame len=%0d want=60 diff=%0d", out_q.size(), first_diff()); end
    n_cmp++;
    if (last_count() != 1 || last_pos() != 59 || done_cnt != 1) begin
      n_bad++; $display("FAIL min_tlast count=%0d pos=%0d done=%0d want 1/59/1", last_count(), last_pos(), done_cnt);
    end
  endtask

  task automatic test_truncate();
    run_frame(48'h0010_2030_4050, 16'h0800, 1600, 0, -1);
    build_exp(48'h0010_2030_4050, 16'h0800, 1600);
    n_cmp++;
    if (out_q.size() != 1514 || first_diff() != -1) begin n_bad++; $display("FAIL trunc_frame len=%0d want=1514 diff=%0d", out_q.size(), first_diff()); end
    n_cmp++;
    if (last_count() != 1 || last_pos() != 1513) begin n_bad++; $display("FAIL trunc_tlast count=%0d pos=%0d want 1 at 1513", last_count(), last_pos()); end
    n_cmp++;
    if (trunc_cnt != 1 || done_cnt != 1) begin n_bad++; $display("FAIL trunc_pulses done=%0d trunc=%0d want 1/1", done_cnt, trunc_cnt); end
    n_cmp++;
    if (pay_used != 1600 || timed_out) begin n_bad++; $display("FAIL trunc_drain consumed=%0d want=1600 timeout=%0d", pay_used, timed_out); end
  endtask

  task automatic test_stall();
    run_frame(48'h0203_0405_0607, 16'h0800, 60, 1, -1);
    build_exp(48'h0203_0405_0607, 16'h0800, 60);
    n_cmp++;
    if (out_q.size() != 74 || first_diff() != -1 || timed_out) begin n_bad++; $display("FAIL stall_frame len=%0d want=74 diff=%0d", out_q.size(), first_diff()); end
    n_cmp++;
    if (stable_err != 0) begin n_bad++; $display("FAIL stall_hold unstable=%0d want=0", stable_err); end
    n_cmp++;
    if (hdr_gap != 0) begin n_bad++; $display("FAIL stall_hdr_gap got=%0d want=0", hdr_gap); end
    n_cmp++;
    if (last_count() != 1 || last_pos() != 73 || done_cnt != 1) begin
      n_bad++; $display("FAIL stall_tlast count=%0d pos=%0d done=%0d want 1/73/1", last_count(), last_pos(), done_cnt);
    end
  endtask

  task automatic test_reset_abort();
    run_frame(48'h0102_0304_0506, 16'h0800, 20, 0, 5);
    n_cmp++;
    if (abort_vld !== 1'b0 || abort_done !== 1'b0) begin n_bad++; $display("FAIL abort_hdr vld=%b done=%b want 0/0", abort_vld, abort_done); end
    n_cmp++;
    if (abort_ack !== 1'b1) begin n_bad++; $display("FAIL abort_hdr_ack got=%b want=1", abort_ack); end
    run_frame(48'h0102_0304_0506, 16'h0800, 10, 0, 29);
    n_cmp++;
    if (abort_vld !== 1'b0 || abort_done !== 1'b0 || done_cnt != 0 || last_count() != 0) begin
      n_bad++; $display("FAIL abort_pad vld=%b done=%b pulses=%0d lasts=%0d want 0", abort_vld, abort_done, done_cnt, last_count());
    end
    n_cmp++;
    if (abort_ack !== 1'b1) begin n_bad++; $display("FAIL abort_pad_ack got=%b want=1", abort_ack); end
    run_frame(48'hA1A2_A3A4_A5A6, 16'h0801, 50, 0, -1);
    build_exp(48'hA1A2_A3A4_A5A6, 16'h0801, 50);
    n_cmp++;
    if (out_q.size() != 64 || first_diff() != -1 || last_pos() != 63 || done_cnt != 1) begin
      n_bad++; $display("FAIL post_abort len=%0d diff=%0d lastpos=%0d done=%0d want 64/-1/63/1", out_q.size(), first_diff(), last_pos(), done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(48'h1111_2222_3333, 16'h0800, 47, 0, -1);
    n_cmp++;
    if (end_ack !== 1'b1) begin n_bad++; $display("FAIL b2b_first_idle_ack got=%b want=1", end_ack); end
    run_frame(48'h4444_5555_6666, 16'h88B5, 3, 0, -1);
    build_exp(48'h4444_5555_6666, 16'h88B5, 3);
    n_cmp++;
    if (out_q.size() != 60 || first_diff() != -1 || last_pos() != 59 || done_cnt != 1) begin
      n_bad++; $display("FAIL b2b_second len=%0d diff=%0d lastpos=%0d done=%0d want 60/-1/59/1", out_q.size(), first_diff(), last_pos(), done_cnt);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    bus.tx_req_in = 1'b0; bus.tx_dst_mac_in = 48'd0; bus.tx_ethertype_in = 16'd0;
    bus.pay_tdata_in = 8'h00; bus.pay_tvalid_in = 1'b0; bus.pay_tlast_in = 1'b0;
    bus.mac_tready_in = 1'b1;
    abort_vld = 1'b0; abort_done = 1'b0; abort_ack = 1'b0; end_ack = 1'b0;
    test_reset();
    test_long_payload();
    test_short_pad();
    test_exact_min();
    test_truncate();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
